// File: rtl/game_timer_pkg.sv
// Shared types and constants for the counting-game second-tick timer.
package game_timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t;

    localparam logic MODE_DOWN = 1'b0;
    localparam logic MODE_UP   = 1'b1;

endpackage

// File: rtl/game_timer_tick_prescaler.sv
// Divides clk by DIV; tick flags the last phase of each DIV-cycle period.
module tick_prescaler #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end

    // Decoded from the counter alone; the caller qualifies it with its own state.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/game_timer.sv
// Countdown / count-up game timer with pause, auto-reload, low-time warning and expiry strobe.
module game_timer
    import game_timer_pkg::*;
#(
    parameter int CNT_W   = 3,
    parameter int DIV     = 1000,
    parameter int WARN_TH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             mode,
    input  logic             auto_reload,
    input  logic             start,
    input  logic             pause,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             running,
    output logic             paused,
    output logic             expired,
    output logic             expire_pulse,
    output logic             warn
);

    localparam logic [CNT_W-1:0] WARN_V = CNT_W'(WARN_TH);

    timer_state_t     state, state_n;
    logic [CNT_W-1:0] count_n, limit, limit_n;
    logic             mode_q, mode_n, reload_q, reload_n, pulse_n;
    logic             presc_clr, presc_en, wrap;
    logic [CNT_W-1:0] target, remaining, reload_val, step_val;

    tick_prescaler #(.DIV(DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (wrap)
    );

    assign target     = (mode_q == MODE_UP) ? limit : '0;
    assign remaining  = (mode_q == MODE_UP) ? limit - count : count;
    assign reload_val = (mode_q == MODE_UP) ? '0 : limit;
    assign step_val   = (mode_q == MODE_UP) ? count + 1'b1 : count - 1'b1;

    always_comb begin
        state_n   = state;
        count_n   = count;
        limit_n   = limit;
        mode_n    = mode_q;
        reload_n  = reload_q;
        pulse_n   = 1'b0;
        presc_clr = 1'b0;
        presc_en  = 1'b0;
        if (load) begin
            count_n   = (mode == MODE_UP) ? '0 : load_val;
            limit_n   = load_val;
            mode_n    = mode;
            reload_n  = auto_reload;
            presc_clr = 1'b1;
            state_n   = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        presc_clr = 1'b1;
                        if (count == target) begin
                            state_n = DONE;
                            pulse_n = 1'b1;
                        end else begin
                            state_n = RUN;
                        end
                    end
                end
                DONE: begin
                    // A zero-length period has nothing to run, so it stays expired.
                    if (start && reload_val != target) begin
                        presc_clr = 1'b1;
                        count_n   = reload_val;
                        state_n   = RUN;
                    end
                end
                default: begin
                    // RUN and PAUSE share this path: the prescaler advances on the
                    // resume cycle itself, so a pause adds exactly its own length.
                    if (pause) begin
                        state_n = PAUSE;
                    end else begin
                        state_n  = RUN;
                        presc_en = 1'b1;
                        if (wrap) begin
                            count_n = step_val;
                            if (step_val == target) begin
                                pulse_n = 1'b1;
                                if (reload_q)
                                    count_n = reload_val;
                                else
                                    state_n = DONE;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            limit        <= '0;
            mode_q       <= MODE_DOWN;
            reload_q     <= 1'b0;
            expire_pulse <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            limit        <= limit_n;
            mode_q       <= mode_n;
            reload_q     <= reload_n;
            expire_pulse <= pulse_n;
        end
    end

    assign running = (state == RUN);
    assign paused  = (state == PAUSE);
    assign expired = (state == DONE);
    assign tick    = running && wrap;
    assign warn    = (running || paused) && (remaining <= WARN_V);

endmodule

// File: tb/tb_game_timer.sv
// Scoreboarded bench: a spec-level model predicts every cycle, a monitor compares on negedge.
module tb_game_timer;

    localparam int CNT_W = 4, DIV = 4, WARN_TH = 1;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic clk = 1'b0, rst = 1'b1;
    logic load = 1'b0, mode = 1'b0, auto_reload = 1'b0, start = 1'b0, pause = 1'b0;
    logic [CNT_W-1:0] load_val = '0;
    logic [CNT_W-1:0] count;
    logic tick, running, paused, expired, expire_pulse, warn;

    always #5 clk = ~clk;

    game_timer #(.CNT_W(CNT_W), .DIV(DIV), .WARN_TH(WARN_TH)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .mode(mode),
        .auto_reload(auto_reload), .start(start), .pause(pause), .count(count),
        .tick(tick), .running(running), .paused(paused), .expired(expired),
        .expire_pulse(expire_pulse), .warn(warn)
    );

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic tk, run, pse, exp, pls, wrn;
    } obs_t;

    obs_t q[$];
    int n_vec = 0, n_err = 0;

    // Reference model: game state, count, end value and elapsed cycles within the current tick.
    int m_st = S_IDLE, m_cnt = 0, m_lim = 0, m_ph = 0;
    bit m_up = 0, m_rl = 0, m_pls = 0;

    function automatic obs_t predict();
        obs_t o;
        int rem;
        rem   = m_up ? m_lim - m_cnt : m_cnt;
        o.cnt = m_cnt[CNT_W-1:0];
        o.tk  = (m_st == S_RUN) && (m_ph == DIV - 1);
        o.run = (m_st == S_RUN);
        o.pse = (m_st == S_PAUSE);
        o.exp = (m_st == S_DONE);
        o.pls = m_pls;
        o.wrn = (m_st == S_RUN || m_st == S_PAUSE) && rem <= WARN_TH;
        return o;
    endfunction

    always @(posedge clk) begin
        int tgt, nxt;
        tgt   = m_up ? m_lim : 0;
        m_pls = 0;
        if (rst) begin
            m_st = S_IDLE; m_cnt = 0; m_lim = 0; m_ph = 0; m_up = 0; m_rl = 0;
        end else if (load) begin
            m_up = mode; m_rl = auto_reload; m_lim = int'(load_val);
            m_cnt = mode ? 0 : int'(load_val); m_ph = 0; m_st = S_IDLE;
        end else if (m_st == S_IDLE) begin
            if (start) begin
                m_ph = 0;
                if (m_cnt == tgt) begin m_st = S_DONE; m_pls = 1; end
                else m_st = S_RUN;
            end
        end else if (m_st == S_DONE) begin
            if (start && (m_up ? 0 : m_lim) != tgt) begin
                m_cnt = m_up ? 0 : m_lim; m_ph = 0; m_st = S_RUN;
            end
        end else if (pause) begin
            m_st = S_PAUSE;
        end else begin
            m_st = S_RUN;
            if (m_ph < DIV - 1) begin
                m_ph++;
            end else begin
                m_ph = 0;
                nxt  = m_up ? m_cnt + 1 : m_cnt - 1;
                if (nxt == tgt) begin
                    m_pls = 1;
                    if (m_rl) m_cnt = m_up ? 0 : m_lim;
                    else begin m_cnt = nxt; m_st = S_DONE; end
                end else begin
                    m_cnt = nxt;
                end
            end
        end
        q.push_back(predict());
    end

    always @(negedge clk) begin
        obs_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {count, tick, running, paused, expired, expire_pulse, warn};
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL scoreboard t=%0t got cnt=%0d tk%b run%b pse%b exp%b pls%b wrn%b want cnt=%0d tk%b run%b pse%b exp%b pls%b wrn%b",
                         $time, a.cnt, a.tk, a.run, a.pse, a.exp, a.pls, a.wrn,
                         e.cnt, e.tk, e.run, e.pse, e.exp, e.pls, e.wrn);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic cyc(input bit ld, input int lv, input bit md, input bit ar, input bit st, input bit ps);
        load = ld; load_val = lv[CNT_W-1:0]; mode = md; auto_reload = ar; start = st; pause = ps;
        @(posedge clk); @(negedge clk); #1;
    endtask

    task automatic idle(); cyc(0, 0, 0, 0, 0, 0); endtask

    // Cycles until the next expire_pulse, bounded.
    task automatic to_pulse(output int n);
        n = 0;
        do begin idle(); n++; end while (!expire_pulse && n < 60);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        #1;
        check("reset_count", int'(count), 0);
        check("reset_flags", int'({tick, running, paused, expired, expire_pulse, warn}), 0);
        rst = 1'b0;

        cyc(1, 3, 0, 0, 0, 0); cyc(0, 0, 0, 0, 1, 0);
        to_pulse(n);
        check("down_expiry_cycles", n, 12);
        check("down_expired", int'(expired), 1);

        cyc(1, 3, 0, 0, 0, 0); cyc(0, 0, 0, 0, 1, 0);
        repeat (4) idle();
        check("pause_count_before", int'(count), 2);
        repeat (5) cyc(0, 0, 0, 0, 0, 1);
        check("pause_count_frozen", int'(count), 2);
        check("pause_state", int'(paused), 1);
        to_pulse(n);
        check("pause_expiry_cycles", 9 + n, 17);

        cyc(1, 5, 1, 0, 0, 0); cyc(0, 0, 0, 0, 1, 0);
        to_pulse(n);
        check("up_expiry_cycles", n, 20);
        check("up_final_count", int'(count), 5);

        cyc(1, 2, 0, 1, 0, 0); cyc(0, 0, 0, 0, 1, 0);
        to_pulse(n);
        check("reload_first", n, 8);
        to_pulse(n);
        check("reload_second", n, 8);
        check("reload_not_expired", int'(expired), 0);
        check("reload_count", int'(count), 2);

        cyc(1, 0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 1, 0);
        check("zero_pulse", int'(expire_pulse), 1);
        check("zero_expired", int'(expired), 1);
        idle();
        check("zero_single_pulse", int'(expire_pulse), 0);

        cyc(1, 3, 0, 0, 0, 0); cyc(0, 0, 0, 0, 1, 0);
        repeat (2) idle();
        cyc(0, 0, 0, 0, 1, 0);
        to_pulse(n);
        check("start_in_run_ignored", 3 + n, 12);

        cyc(1, 3, 0, 0, 0, 0); cyc(0, 0, 0, 0, 1, 0);
        repeat (4) idle();
        check("rst_pre_count", int'(count), 2);
        rst = 1'b1;
        #1;
        check("rst_async_count", int'(count), 0);
        check("rst_async_flags", int'({tick, running, paused, expired, expire_pulse, warn}), 0);
        idle();
        rst = 1'b0;

        cyc(1, 3, 0, 0, 0, 0); cyc(0, 0, 0, 0, 1, 0);
        repeat (2) idle();
        cyc(1, 7, 0, 0, 0, 0);
        check("load_mid_count", int'(count), 7);
        check("load_mid_running", int'(running), 0);
        repeat (8) idle();
        check("load_mid_held", int'(count), 7);

        for (int i = 0; i < 1500; i++) begin
            bit ps_next;
            ps_next = ($urandom_range(0, 11) == 0) ? ~pause : pause;
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            cyc($urandom_range(0, 29) == 0, $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, ps_next);
            rst = 1'b0;
        end

        repeat (3) idle();
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog bench did not finish");
        $fatal(1);
    end

endmodule
